harness_source: RTL and testbench

Benchmarking-harness stimulus generator; the transmit-side counterpart of the harness sink. On `start` it emits a configurable number of pseudo-random `WIDTH`-bit beats on an AXI-Stream master port into the DUT. Beats come from a 32-bit LFSR. It keeps a running XOR-parity of every transferred beat so the host can compare it against the parity the sink reduces from the DUT output path.

---
 rtl/harness_source.sv | 151 +++++++++++++++
 tb/tb_harness_source.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/harness_source.sv
// harness_source -- benchmarking-harness stimulus generator.
//
// On an accepted start, emits cfg_count pseudo-random beats on an AXI-Stream
// master port. Beat data comes from a 32-bit Fibonacci LFSR
// (x^32+x^22+x^2+x+1). Lane k of the beat is the LFSR state XOR k, and the
// lanes are truncated to WIDTH. A running XOR-parity and a beat counter
// cover every transferred beat, so the host can compare them against the sink.
//
// Ports:
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   start                    single-cycle run request (honoured in IDLE/DONE)
//   cfg_count, cfg_seed      beat count and LFSR seed, sampled with start
//   m_axis_tdata/tvalid/
//   m_axis_tready/tlast      AXI-Stream master
//   busy, done               FSM in RUN / FSM in DONE
//   parity, beats_sent       running XOR-parity and handshake count of the run
module harness_source #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [31:0]      cfg_seed,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done,
  output logic             parity,
  output logic [CNT_W-1:0] beats_sent
);

  localparam int NL = (WIDTH + 31) / 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;

  logic             handshake;
  logic [31:0]      seed_eff;
  logic [31:0]      lfsr_next;

  // Beat data for a given LFSR state: lane k = state ^ k, truncated to WIDTH.
  function automatic logic [WIDTH-1:0] map_beat(input logic [31:0] s);
    logic [NL*32-1:0] w;
    for (int k = 0; k < NL; k++) begin
      w[32*k +: 32] = s ^ 32'(k);
    end
    return w[WIDTH-1:0];
  endfunction

  assign handshake = tvalid_q & m_axis_tready;

  always_comb begin
    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    seed_eff  = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
    lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    lfsr_d      = lfsr_q;
    parity_d    = parity_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          remaining_d = cfg_count;
          lfsr_d      = seed_eff;
          parity_d    = 1'b0;
          beats_d     = '0;
          if (cfg_count != '0) begin
            // The first beat is presented right after the accepting edge.
            state_d  = S_RUN;
            tvalid_d = 1'b1;
            tdata_d  = map_beat(seed_eff);
            tlast_d  = (cfg_count == CNT_W'(1));
          end else begin
            state_d  = S_DONE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (handshake) begin
          lfsr_d      = lfsr_next;
          parity_d    = parity_q ^ (^tdata_q);
          beats_d     = beats_q + CNT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          if (tlast_q) begin
            state_d  = S_DONE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            // Next beat becomes the last one when exactly one remains after this.
            tdata_d = map_beat(lfsr_next);
            tlast_d = (remaining_q == CNT_W'(2));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      beats_q     <= '0;
      lfsr_q      <= '0;
      parity_q    <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      lfsr_q      <= lfsr_d;
      parity_q    <= parity_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign parity        = parity_q;
  assign beats_sent    = beats_q;

endmodule

// File: tb/tb_harness_source.sv
// Self-checking bench for harness_source: an 8-bit and a 72-bit instance
// share one stimulus stream. A queue-based model predicts every output at
// each falling edge; directed tasks add literal expectations.
module tb_harness_source;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_count = '0;
  logic [31:0] cfg_seed = '0;
  logic        tready = 1'b0;

  logic [7:0]  tdata8;
  logic        tvalid8, tlast8, busy8, done8, parity8;
  logic [31:0] beats8;
  logic [71:0] tdata72;
  logic        tvalid72, tlast72, busy72, done72, parity72;
  logic [31:0] beats72;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 ap_clk = ~ap_clk;

  harness_source #(.WIDTH(8), .CNT_W(32)) dut8 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
    .cfg_count(cfg_count), .cfg_seed(cfg_seed),
    .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready),
    .m_axis_tlast(tlast8), .busy(busy8), .done(done8), .parity(parity8),
    .beats_sent(beats8)
  );

  harness_source #(.WIDTH(72), .CNT_W(32)) dut72 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
    .cfg_count(cfg_count), .cfg_seed(cfg_seed),
    .m_axis_tdata(tdata72), .m_axis_tvalid(tvalid72), .m_axis_tready(tready),
    .m_axis_tlast(tlast72), .busy(busy72), .done(done72), .parity(parity72),
    .beats_sent(beats72)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [71:0] beat72(input logic [31:0] s);
    logic [31:0] l2;
    l2 = s ^ 32'd2;
    return {l2[7:0], s ^ 32'd1, s};
  endfunction

  logic [71:0] exp_q[$];
  logic        m_run = 1'b0;
  logic        m_done = 1'b0;
  logic        m_par8 = 1'b0;
  logic        m_par72 = 1'b0;
  logic [31:0] m_beats = '0;

  initial begin
    forever begin
      @(posedge ap_clk or negedge ap_rst_n);
      if (!ap_rst_n) begin
        exp_q.delete();
        m_run = 1'b0; m_done = 1'b0; m_par8 = 1'b0; m_par72 = 1'b0; m_beats = '0;
      end else if (m_run) begin
        if (tready) begin
          m_par8  = m_par8 ^ (^exp_q[0][7:0]);
          m_par72 = m_par72 ^ (^exp_q[0]);
          m_beats = m_beats + 1;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_run = 1'b0; m_done = 1'b1;
          end
        end
      end else if (start) begin
        logic [31:0] s;
        s = (cfg_seed == 0) ? 32'd1 : cfg_seed;
        exp_q.delete();
        for (int i = 0; i < int'(cfg_count); i++) begin
          exp_q.push_back(beat72(s));
          s = step(s);
        end
        m_par8 = 1'b0; m_par72 = 1'b0; m_beats = '0;
        m_run  = (cfg_count != 0);
        m_done = (cfg_count == 0);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      chk("tvalid8", 72'(tvalid8), 72'(m_run));
      chk("busy8", 72'(busy8), 72'(m_run));
      chk("done8", 72'(done8), 72'(m_done));
      chk("parity8", 72'(parity8), 72'(m_par8));
      chk("beats8", 72'(beats8), 72'(m_beats));
      chk("tvalid72", 72'(tvalid72), 72'(m_run));
      chk("done72", 72'(done72), 72'(m_done));
      chk("parity72", 72'(parity72), 72'(m_par72));
      chk("beats72", 72'(beats72), 72'(m_beats));
      if (m_run) begin
        chk("tdata8", 72'(tdata8), 72'(exp_q[0][7:0]));
        chk("tlast8", 72'(tlast8), 72'(exp_q.size() == 1));
        chk("tdata72", tdata72, exp_q[0]);
        chk("tlast72", 72'(tlast72), 72'(exp_q.size() == 1));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_start(input logic [31:0] seed, input logic [31:0] cnt);
    cfg_seed = seed; cfg_count = cnt; start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
  endtask

  // Runs until done with tready following a 4-cycle pattern (bit 0 first).
  task automatic run_to_done(input logic [3:0] pat, input int max_cyc);
    int c = 0;
    while (!done8 && c < max_cyc) begin
      tready = pat[c % 4];
      @(negedge ap_clk);
      c++;
    end
    chk("run_timeout", 72'(done8), 72'd1);
  endtask

  task automatic expect_run_end(input string tag, input logic par, input logic [31:0] n);
    chk({tag, "_done"}, 72'(done8), 72'd1);
    chk({tag, "_busy"}, 72'(busy8), 72'd0);
    chk({tag, "_tvalid"}, 72'(tvalid8), 72'd0);
    chk({tag, "_parity"}, 72'(parity8), 72'(par));
    chk({tag, "_beats"}, 72'(beats8), 72'(n));
  endtask

  initial begin
    // Reset values
    #23;
    chk("rst_tvalid", 72'(tvalid8), 72'd0);
    chk("rst_tlast", 72'(tlast8), 72'd0);
    chk("rst_tdata72", tdata72, 72'd0);
    chk("rst_done", 72'(done8), 72'd0);
    chk("rst_busy", 72'(busy8), 72'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Basic run: seed 1, count 4, tready=1
    tready = 1'b1;
    do_start(32'd1, 32'd4);
    chk("basic_b0", 72'(tdata8), 72'h01);
    chk("wide_b0", tdata72, 72'h03_00000000_00000001);
    chk("basic_busy", 72'(busy8), 72'd1);
    @(negedge ap_clk);
    chk("basic_b1", 72'(tdata8), 72'h03);
    @(negedge ap_clk);
    chk("basic_b2", 72'(tdata8), 72'h06);
    chk("basic_nolast", 72'(tlast8), 72'd0);
    @(negedge ap_clk);
    chk("basic_b3", 72'(tdata8), 72'h0D);
    chk("basic_last", 72'(tlast8), 72'd1);
    @(negedge ap_clk);
    expect_run_end("basic", 1'b0, 32'd4);

    // Backpressure, count 3 -> parity 1; stability checked by the model
    do_start(32'd1, 32'd3);
    run_to_done(4'b1001, 60);
    expect_run_end("bp", 1'b1, 32'd3);

    // Backpressure, count 4 -> same sequence, parity 0
    do_start(32'd1, 32'd4);
    run_to_done(4'b1001, 60);
    expect_run_end("bp4", 1'b0, 32'd4);

    // Zero count
    tready = 1'b1;
    do_start(32'd9, 32'd0);
    chk("zero_done", 72'(done8), 72'd1);
    chk("zero_tvalid", 72'(tvalid8), 72'd0);
    chk("zero_parity", 72'(parity8), 72'd0);
    chk("zero_beats", 72'(beats8), 72'd0);

    // Seed 0 behaves as seed 1
    do_start(32'd0, 32'd2);
    chk("seed0_b0", 72'(tdata8), 72'h01);
    @(negedge ap_clk);
    chk("seed0_b1", 72'(tdata8), 72'h03);
    @(negedge ap_clk);
    expect_run_end("seed0", 1'b1, 32'd2);

    // Start pulsed mid-run is ignored
    do_start(32'd1, 32'd4);
    @(negedge ap_clk);
    do_start(32'd5, 32'd7);
    chk("ign_b2", 72'(tdata8), 72'h06);
    run_to_done(4'b1111, 20);
    expect_run_end("ign", 1'b0, 32'd4);

    // Restart from DONE with seed 6
    do_start(32'd6, 32'd5);
    chk("restart_b0", 72'(tdata8), 72'h06);
    chk("restart_parity", 72'(parity8), 72'd0);
    chk("restart_beats", 72'(beats8), 72'd0);
    run_to_done(4'b0111, 40);
    chk("restart_beats_end", 72'(beats8), 72'd5);

    // Long run with mixed backpressure
    do_start(32'hDEADBEEF, 32'd23);
    run_to_done(4'b1101, 100);
    chk("long_beats", 72'(beats8), 72'd23);

    // Async reset during a stalled beat
    tready = 1'b0;
    do_start(32'd1, 32'd10);
    @(negedge ap_clk);
    chk("stall_tvalid", 72'(tvalid8), 72'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 72'(tvalid8), 72'd0);
    chk("arst_tvalid72", 72'(tvalid72), 72'd0);
    chk("arst_tlast", 72'(tlast8), 72'd0);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_tdata", 72'(tdata8), 72'd0);
    chk("post_tdata72", tdata72, 72'd0);
    chk("post_busy", 72'(busy8), 72'd0);
    chk("post_done", 72'(done8), 72'd0);
    chk("post_parity", 72'(parity8), 72'd0);
    chk("post_beats", 72'(beats8), 72'd0);

    // FSM is back in IDLE: a fresh run starts normally
    tready = 1'b1;
    do_start(32'd1, 32'd1);
    chk("idle_b0", 72'(tdata8), 72'h01);
    chk("idle_last", 72'(tlast8), 72'd1);
    @(negedge ap_clk);
    expect_run_end("idle", 1'b1, 32'd1);

    @(negedge ap_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
